druaga_ioctl_loader: RTL and testbench
======================================

# druaga_ioctl_loader

Front-end loader between the HPS ioctl download stream and the Druaga game core.
- Decodes the download index into three targets: ROM image bytes, title number, and DIP switch bytes.
- Drives registered ROM write strobes into the core.
- Holds the core in reset while a download is in progress and for a fixed time after it ends.
- Presents the per-title DSW0/DSW1/DSW2 mapping to the core.

## Interface
Parameters:
- ROM_AW, 17: ROM address width. Bytes at addresses ≥ 2^ROM_AW are dropped and set `rom_ovf`.
- HOLD_CYCLES, 1024: number of clk_sys cycles that `core_reset` stays asserted after `ioctl_download` falls.

Ports:
- clk_sys  in  1: system clock, 48 MHz. This is the only clock.
- rst_n  in  1: asynchronous, active-low reset.
- ioctl_download  in  1: download in progress.
- ioctl_wr  in  1: byte strobe, one cycle wide.
- ioctl_addr  in  25: byte address within the current index.
- ioctl_dout  in  8: byte data.
- ioctl_index  in  8: download target. 0 = ROM, 1 = title number, 254 = DIP.
- rom_we  out  1: registered ROM write strobe.
- rom_addr  out  ROM_AW: registered ROM address.
- rom_data  out  8: registered ROM data.
- tno  out  4: title number.
- dsw0, dsw1, dsw2  out  8 each: DIP switch bytes, mapped per title.
- core_reset  out  1: active-high reset to the game core.
- dl_done  out  1: one-cycle pulse when a ROM load completes.
- checksum  out  8: modulo-256 sum of the ROM bytes accepted in the last ROM download.
- rom_ovf  out  1: a ROM byte was dropped as out of range in the current download.

## Operation
State machine states: IDLE, LOAD_ROM, LOAD_TNO, LOAD_DIP, LOAD_OTHER, HOLD.

Transitions:
- IDLE → LOAD_* on `ioctl_download` rising. The index is sampled on that cycle and latched for the whole download. Any index other than 0, 1 or 254 goes to LOAD_OTHER, which ignores all bytes.
- LOAD_* → HOLD on `ioctl_download` falling. The hold counter loads HOLD_CYCLES-1.
- HOLD → IDLE when the counter reaches 0. That same cycle pulses `dl_done`, but only if the latched index was 0.
- HOLD → LOAD_* if `ioctl_download` rises again during HOLD. The counter is abandoned and `dl_done` is not pulsed.

Byte handling:
- `ioctl_wr` is honoured only in a LOAD_* state. Strobes in IDLE or HOLD are ignored.
- LOAD_ROM:
  - If `ioctl_addr[24:ROM_AW]==0`: `rom_we`, `rom_addr` and `rom_data` are registered from the strobe, and `checksum += ioctl_dout`.
  - Otherwise: no `rom_we` is issued and `rom_ovf` is set to 1.
  - Entering LOAD_ROM clears `checksum` and `rom_ovf`.
- LOAD_TNO: `tno <= ioctl_dout[3:0]` on every strobe, so the last byte wins.
- LOAD_DIP: `sw[ioctl_addr[2:0]] <= ioctl_dout`, only when `ioctl_addr[24:3]==0`. There are 8 sw bytes; only sw0..sw2 are observable.

DSW mapping (combinational from `tno` and sw):
- tno 1 or 3: dsw0=sw0, dsw1=sw1, dsw2={sw1[3:0], sw2[3:0]}.
- tno 2: dsw0=sw0, dsw1=sw1, dsw2={sw2[3:0], sw2[3:0]}.
- All other tno values: dsw0=sw0, dsw1=sw1, dsw2=sw2.

`core_reset` = 1 in every state except IDLE.

## Timing
Reset values (while `rst_n`=0):
- State = IDLE.
- core_reset=1. It is forced high asynchronously during reset and released in IDLE on the first clock after `rst_n` rises.
- rom_we=0, rom_addr=0, rom_data=0.
- tno=0, all sw bytes=0, so dsw0..dsw2=0.
- checksum=0, rom_ovf=0, dl_done=0.

Latencies:
- ROM write: `ioctl_wr` at cycle N gives `rom_we`=1 at N+1 with matching address and data. `rom_we` is exactly one cycle wide per strobe.
- `tno` and sw update at N+1. The dsw outputs follow in the same cycle.
- `checksum` is updated at N+1.

Boundaries and corner cases:
- `core_reset` deasserts exactly HOLD_CYCLES cycles after the first cycle on which `ioctl_download`=0 is sampled.
- `ioctl_wr` on the same cycle as `ioctl_download` falls is still accepted. The state leaves LOAD_* only on the next cycle.
- Checksum arithmetic wraps modulo 256.
- `rst_n` asserted mid-download aborts immediately. After release, the block sits in IDLE even if `ioctl_download` is still high. It re-enters a LOAD state only on the next rising edge of `ioctl_download`.
- `tno` and sw are not cleared by a download start, only by `rst_n`.

## Structure
Package `druaga_pkg` holds:
- The state enum `ldr_state_t`.
- Index constants IDX_ROM=8'd0, IDX_TNO=8'd1, IDX_DIP=8'd254.

Sub-module `reset_stretch` is the hold counter. It has a load input, a count-done pulse output and a parameter HOLD_CYCLES. The FSM, byte decode, DSW mux and checksum live in the top module.

## Test plan
- Power-up: `rst_n` low for 5 cycles, then high, with no download. Expect core_reset=1 during reset, 0 one cycle after release, and all dsw=0.
- ROM load: index 0, bytes 0x10, 0x20, 0xF5 at addresses 0–2. Expect three one-cycle `rom_we` pulses with matching addr/data, checksum=0x25, rom_ovf=0, core_reset low after exactly HOLD_CYCLES, and dl_done pulsing once on that cycle.
- Out of range: with ROM_AW=17, write at address 0x20000. Expect no `rom_we` and rom_ovf=1. A new ROM download clears rom_ovf to 0.
- Title and DIP: index 254 with bytes A5, 3C, 7E, then index 1 with byte 0x02. Expect dsw0=A5, dsw1=3C, dsw2=EE. Then index 1 with byte 0x03: expect dsw2=CE. Then byte 0x00: expect dsw2=7E. After an index-1 download, dl_done stays 0.
- Re-download in HOLD: drop `ioctl_download`, raise it again 10 cycles later. Expect core_reset to stay 1 throughout, no dl_done, and a fresh HOLD_CYCLES count after the second fall.
- Mid-download reset: pulse `rst_n` low during a ROM stream with `ioctl_download` still high. Expect core_reset=1 while `rst_n` is low and 0 after release, with no `rom_we` while `ioctl_download` stays high. Expect no `rom_we` until the next rising edge of `ioctl_download`.

Source files
------------

// File: rtl/druaga_ioctl_loader_pkg.sv
// Shared types and constants for the Druaga ioctl loader.
//   ldr_state_t  : loader FSM state encoding
//   IDX_*        : ioctl_index values that select a download target
//   load_state() : maps a sampled download index to its LOAD_* state
package druaga_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_ROM   = 3'd1,
        LOAD_TNO   = 3'd2,
        LOAD_DIP   = 3'd3,
        LOAD_OTHER = 3'd4,
        HOLD       = 3'd5
    } ldr_state_t;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_TNO = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    function automatic ldr_state_t load_state(input logic [7:0] idx);
        case (idx)
            IDX_ROM: return LOAD_ROM;
            IDX_TNO: return LOAD_TNO;
            IDX_DIP: return LOAD_DIP;
            default: return LOAD_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/druaga_ioctl_loader_if.sv
// HPS ioctl download bus.
//   ioctl_download : download in progress
//   ioctl_wr       : one-cycle byte strobe
//   ioctl_addr     : byte address within the current index
//   ioctl_dout     : byte data
//   ioctl_index    : download target selector
// master = HPS side (drives), slave = loader (receives).
interface druaga_ioctl_loader_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index
    );

    modport slave (
        input ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index
    );
endinterface

// File: rtl/druaga_ioctl_loader_reset_stretch.sv
// Hold counter that stretches the core reset after a download ends.
//   clk_sys, rst_n : clock, async active-low reset
//   load           : (re)start the count at HOLD_CYCLES-1
//   done           : high on the cycle the running count sits at zero;
//                    the count stops after that cycle
module reset_stretch #(
    parameter int HOLD_CYCLES = 1024
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic load,
    output logic done
);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [CW-1:0] count;
    logic          active;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            active <= 1'b0;
        end else if (load) begin
            count  <= CW'(HOLD_CYCLES - 1);
            active <= 1'b1;
        end else if (active) begin
            if (count == '0) begin
                active <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign done = active && (count == '0);

endmodule

// File: rtl/druaga_ioctl_loader.sv
// Loader between the HPS ioctl download stream and the Druaga core.
//   clk_sys, rst_n   : 48 MHz clock, async active-low reset
//   io               : ioctl download bus (slave side)
//   rom_we/addr/data : registered ROM write port into the core
//   tno              : title number
//   dsw0..dsw2       : DIP switch bytes after per-title remapping
//   core_reset       : active-high core reset, held through download + HOLD_CYCLES
//   dl_done          : one-cycle pulse when a ROM download's hold period ends
//   checksum         : mod-256 sum of ROM bytes accepted in the last ROM download
//   rom_ovf          : a ROM byte beyond 2^ROM_AW was dropped in this download
module druaga_ioctl_loader
    import druaga_pkg::*;
#(
    parameter int ROM_AW      = 17,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    druaga_ioctl_loader_if.slave  io,
    output logic                  rom_we,
    output logic [ROM_AW-1:0]     rom_addr,
    output logic [7:0]            rom_data,
    output logic [3:0]            tno,
    output logic [7:0]            dsw0,
    output logic [7:0]            dsw1,
    output logic [7:0]            dsw2,
    output logic                  core_reset,
    output logic                  dl_done,
    output logic [7:0]            checksum,
    output logic                  rom_ovf
);

    ldr_state_t state, state_nxt;
    logic [7:0] idx_l;
    logic       dl_prev;
    logic [7:0] sw0, sw1, sw2;
    logic       dl_rise;
    logic       in_load;
    logic       hold_load;
    logic       hold_done;
    logic       entering;
    logic       in_range;

    // dl_prev resets high so a download still active across rst_n release
    // does not look like a new rising edge.
    assign dl_rise   = io.ioctl_download && !dl_prev;
    assign in_load   = (state == LOAD_ROM) || (state == LOAD_TNO) ||
                       (state == LOAD_DIP) || (state == LOAD_OTHER);
    assign hold_load = in_load && !io.ioctl_download;
    assign entering  = ((state == IDLE) || (state == HOLD)) &&
                       (state_nxt != IDLE) && (state_nxt != HOLD);
    assign in_range  = (io.ioctl_addr >> ROM_AW) == 25'd0;

    reset_stretch #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .load    (hold_load),
        .done    (hold_done)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (dl_rise) state_nxt = load_state(io.ioctl_index);
            end
            LOAD_ROM, LOAD_TNO, LOAD_DIP, LOAD_OTHER: begin
                if (!io.ioctl_download) state_nxt = HOLD;
            end
            HOLD: begin
                if (dl_rise)        state_nxt = load_state(io.ioctl_index);
                else if (hold_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx_l      <= IDX_ROM;
            dl_prev    <= 1'b1;
            core_reset <= 1'b1;
            dl_done    <= 1'b0;
            rom_we     <= 1'b0;
            rom_addr   <= '0;
            rom_data   <= '0;
            tno        <= '0;
            sw0        <= '0;
            sw1        <= '0;
            sw2        <= '0;
            checksum   <= '0;
            rom_ovf    <= 1'b0;
        end else begin
            state      <= state_nxt;
            dl_prev    <= io.ioctl_download;
            core_reset <= (state_nxt != IDLE);
            dl_done    <= (state == HOLD) && (state_nxt == IDLE) && (idx_l == IDX_ROM);
            rom_we     <= 1'b0;

            // Strobes act on the current state, so a byte on the falling
            // edge of ioctl_download still lands before HOLD is entered.
            if (io.ioctl_wr) begin
                case (state)
                    LOAD_ROM: begin
                        if (in_range) begin
                            rom_we   <= 1'b1;
                            rom_addr <= io.ioctl_addr[ROM_AW-1:0];
                            rom_data <= io.ioctl_dout;
                            checksum <= checksum + io.ioctl_dout;
                        end else begin
                            rom_ovf <= 1'b1;
                        end
                    end
                    LOAD_TNO: tno <= io.ioctl_dout[3:0];
                    LOAD_DIP: begin
                        // Bytes 3..7 of the DIP block reach nothing in the
                        // core, so only the first three are kept.
                        if (io.ioctl_addr[24:3] == 22'd0) begin
                            case (io.ioctl_addr[2:0])
                                3'd0:    sw0 <= io.ioctl_dout;
                                3'd1:    sw1 <= io.ioctl_dout;
                                3'd2:    sw2 <= io.ioctl_dout;
                                default: ;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end

            if (entering) begin
                idx_l <= io.ioctl_index;
                if (state_nxt == LOAD_ROM) begin
                    checksum <= '0;
                    rom_ovf  <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        dsw0 = sw0;
        dsw1 = sw1;
        dsw2 = sw2;
        case (tno)
            4'd1, 4'd3: dsw2 = {sw1[3:0], sw2[3:0]};
            4'd2:       dsw2 = {sw2[3:0], sw2[3:0]};
            default:    ;
        endcase
    end

endmodule

// File: tb/tb_druaga_ioctl_loader.sv
module tb_druaga_ioctl_loader;
    localparam int ROM_AW = 17;
    localparam int HOLD   = 1024;

    logic              clk_sys = 1'b0;
    logic              rst_n   = 1'b0;
    logic              rom_we;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [3:0]        tno;
    logic [7:0]        dsw0, dsw1, dsw2;
    logic              core_reset;
    logic              dl_done;
    logic [7:0]        checksum;
    logic              rom_ovf;

    int n_cmp = 0;
    int n_err = 0;
    int we_cnt = 0;
    int done_cnt = 0;

    druaga_ioctl_loader_if bus ();

    druaga_ioctl_loader #(
        .ROM_AW      (ROM_AW),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .io         (bus),
        .rom_we     (rom_we),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .tno        (tno),
        .dsw0       (dsw0),
        .dsw1       (dsw1),
        .dsw2       (dsw2),
        .core_reset (core_reset),
        .dl_done    (dl_done),
        .checksum   (checksum),
        .rom_ovf    (rom_ovf)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (rom_we === 1'b1)  we_cnt++;
        if (dl_done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_byte(input logic [24:0] addr, input logic [7:0] data);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = addr;
        bus.ioctl_dout = data;
        tick();
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        tick();
    endtask

    // Drop ioctl_download and walk through the hold period, checking the
    // exact release cycle and whether dl_done fires there.
    task automatic finish_dl(input string tag, input logic exp_done);
        int d0;
        bus.ioctl_download = 1'b0;
        tick();
        d0 = done_cnt;
        repeat (HOLD - 1) tick();
        chk({tag, "_rst_before"}, 32'(core_reset), 32'd1);
        tick();
        chk({tag, "_rst_release"}, 32'(core_reset), 32'd0);
        chk({tag, "_dl_done"}, 32'(dl_done), 32'(exp_done));
        tick();
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), exp_done ? 32'd1 : 32'd0);
    endtask

    initial begin
        int w0;
        int d0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.ioctl_index    = '0;

        // Power-up
        repeat (5) tick();
        chk("por_core_reset", 32'(core_reset), 32'd1);
        chk("por_rom_we", 32'(rom_we), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("por_release", 32'(core_reset), 32'd0);
        chk("por_dsw", {8'h0, dsw0, dsw1, dsw2}, 32'h0);
        chk("por_checksum", 32'(checksum), 32'd0);

        // ROM load
        w0 = we_cnt;
        start_dl(8'd0);
        chk("rom_core_reset", 32'(core_reset), 32'd1);
        wr_byte(25'd0, 8'h10);
        chk("rom_b0", {13'h0, rom_we, rom_addr[9:0], rom_data}, {13'h0, 1'b1, 10'd0, 8'h10});
        chk("rom_b0_cs", 32'(checksum), 32'h10);
        tick();
        chk("rom_we_width", 32'(rom_we), 32'd0);
        wr_byte(25'd1, 8'h20);
        chk("rom_b1", {13'h0, rom_we, rom_addr[9:0], rom_data}, {13'h0, 1'b1, 10'd1, 8'h20});
        tick();
        wr_byte(25'd2, 8'hF5);
        chk("rom_b2", {13'h0, rom_we, rom_addr[9:0], rom_data}, {13'h0, 1'b1, 10'd2, 8'hF5});
        tick();
        chk("rom_we_count", 32'(we_cnt - w0), 32'd3);
        chk("rom_checksum", 32'(checksum), 32'h25);
        chk("rom_ovf0", 32'(rom_ovf), 32'd0);
        finish_dl("rom", 1'b1);

        // Out of range
        w0 = we_cnt;
        start_dl(8'd0);
        wr_byte(25'h20000, 8'h55);
        chk("ovf_no_we", 32'(rom_we), 32'd0);
        chk("ovf_flag", 32'(rom_ovf), 32'd1);
        chk("ovf_checksum", 32'(checksum), 32'd0);
        wr_byte(25'h1FFFF, 8'h01);
        chk("ovf_top_addr", {14'h0, rom_we, rom_addr}, {14'h0, 1'b1, 17'h1FFFF});
        tick();
        chk("ovf_we_count", 32'(we_cnt - w0), 32'd1);
        finish_dl("ovf", 1'b1);
        start_dl(8'd0);
        chk("ovf_cleared", 32'(rom_ovf), 32'd0);
        finish_dl("ovf2", 1'b1);

        // Title and DIP
        start_dl(8'd254);
        wr_byte(25'd0, 8'hA5);
        chk("dip_sw0_now", 32'(dsw0), 32'hA5);
        wr_byte(25'd1, 8'h3C);
        wr_byte(25'd2, 8'h7E);
        wr_byte(25'd8, 8'hFF);
        finish_dl("dip", 1'b0);
        chk("dip_dsw_tno0", {8'h0, dsw0, dsw1, dsw2}, 32'h00A53C7E);
        start_dl(8'd1);
        wr_byte(25'd0, 8'h02);
        chk("tno2_dsw", {8'h0, dsw0, dsw1, dsw2}, 32'h00A53CEE);
        finish_dl("tno2", 1'b0);
        start_dl(8'd1);
        wr_byte(25'd0, 8'h03);
        chk("tno3_dsw2", 32'(dsw2), 32'hCE);
        chk("tno3_tno", 32'(tno), 32'd3);
        wr_byte(25'd0, 8'hF0);
        chk("tno0_dsw2", 32'(dsw2), 32'h7E);
        finish_dl("tno0", 1'b0);

        // Re-download during HOLD
        d0 = done_cnt;
        start_dl(8'd0);
        wr_byte(25'd0, 8'h11);
        bus.ioctl_download = 1'b0;
        repeat (10) tick();
        chk("redl_hold_rst", 32'(core_reset), 32'd1);
        bus.ioctl_download = 1'b1;
        tick();
        chk("redl_load_rst", 32'(core_reset), 32'd1);
        chk("redl_cs_cleared", 32'(checksum), 32'd0);
        repeat (HOLD + 5) tick();
        chk("redl_still_rst", 32'(core_reset), 32'd1);
        chk("redl_no_done", 32'(done_cnt - d0), 32'd0);
        finish_dl("redl", 1'b1);

        // Mid-download reset
        start_dl(8'd0);
        wr_byte(25'd0, 8'h42);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_core", 32'(core_reset), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rst_release", 32'(core_reset), 32'd0);
        w0 = we_cnt;
        wr_byte(25'd1, 8'h43);
        chk("mid_no_we", 32'(rom_we), 32'd0);
        wr_byte(25'd2, 8'h44);
        tick();
        chk("mid_we_count", 32'(we_cnt - w0), 32'd0);
        chk("mid_core_idle", 32'(core_reset), 32'd0);
        bus.ioctl_download = 1'b0;
        tick();
        tick();
        start_dl(8'd0);
        wr_byte(25'd3, 8'h45);
        chk("mid_new_we", {15'h0, rom_we, rom_addr[7:0], rom_data}, {15'h0, 1'b1, 8'd3, 8'h45});
        finish_dl("mid", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
